cpu_checker_fmt: RTL

- Transmit-side counterpart of the checker's ASCII-to-number path.
- Takes one CPU write event: time, PC, and either a register write (grf number, data) or a memory write (address, data).
- Serialises it as an ASCII checker string, one character per handshake, on a valid/ready byte stream.
- Used by the testbench and by self-check logic to produce strings the checker parses back.

---
 rtl/cpu_checker_fmt_if.sv | 25 ++
 rtl/cpu_checker_fmt.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_checker_fmt_if.sv
// Request/byte-stream bundle between an event producer and the checker-string formatter.
interface cpu_checker_fmt_if;
    logic        start;
    logic        is_mem;
    logic [13:0] time_in;
    logic [31:0] pc_in;
    logic [4:0]  grf_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, is_mem, time_in, pc_in, grf_in, addr_in, data_in, out_ready,
        input  out_char, out_valid, busy, done
    );

    modport slave (
        input  start, is_mem, time_in, pc_in, grf_in, addr_in, data_in, out_ready,
        output out_char, out_valid, busy, done
    );
endinterface

// File: rtl/cpu_checker_fmt.sv
// Serialises one CPU write event as an ASCII checker string, one character per
// valid/ready handshake: "^time@pc: $grf <= data#" or "^time@pc: *addr <= data#".
module cpu_checker_fmt (
    input  logic               clk,
    input  logic               reset,
    cpu_checker_fmt_if.slave   bus
);
    localparam int unsigned TIME_W = 14;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned GRF_W  = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_MARK,
        S_REGADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                mem_q, mem_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [WORD_W-1:0]   pc_q, pc_d, addr_q, addr_d, data_q, data_d;
    logic [GRF_W-1:0]    grf_q, grf_d;
    logic [7:0]          char_q, char_d;
    logic                valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic                fire;
    logic [3:0]          tdig [4];
    logic [3:0]          gdig [2];
    logic [2:0]          t_last, g_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h57 + 8'(n);
    endfunction

    // Nibble i of w, counting from the most significant nibble.
    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
        return 4'(w >> (5'd28 - {i, 2'b00}));
    endfunction

    assign fire = valid_q & bus.out_ready;

    // Decimal digits of the latched time and register number; *_last is the index of the final printed digit.
    always_comb begin
        tdig[3] = 4'(time_q / 14'd1000);
        tdig[2] = 4'((time_q / 14'd100) % 14'd10);
        tdig[1] = 4'((time_q / 14'd10) % 14'd10);
        tdig[0] = 4'(time_q % 14'd10);
        if (time_q >= 14'd1000)     t_last = 3'd3;
        else if (time_q >= 14'd100) t_last = 3'd2;
        else if (time_q >= 14'd10)  t_last = 3'd1;
        else                        t_last = 3'd0;
        gdig[1] = 4'(grf_q / 5'd10);
        gdig[0] = 4'(grf_q % 5'd10);
        g_last  = (grf_q >= 5'd10) ? 3'd1 : 3'd0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        time_d  = time_q;
        pc_d    = pc_q;
        grf_d   = grf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_CARET;
                idx_d   = 3'd0;
                mem_d   = bus.is_mem;
                time_d  = (bus.time_in > 14'd9999) ? 14'd9999 : bus.time_in;
                pc_d    = bus.pc_in;
                grf_d   = bus.grf_in;
                addr_d  = bus.addr_in;
                data_d  = bus.data_in;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_CARET: if (fire) state_d = S_TIME;
            S_TIME: if (fire) begin
                if (idx_q == t_last) begin state_d = S_AT; idx_d = 3'd0; end
                else idx_d = idx_q + 3'd1;
            end
            S_AT: if (fire) state_d = S_PC;
            S_PC: if (fire) begin
                if (idx_q == 3'd7) begin state_d = S_COLON; idx_d = 3'd0; end
                else idx_d = idx_q + 3'd1;
            end
            S_COLON: if (fire) state_d = S_SP1;
            S_SP1:   if (fire) state_d = S_MARK;
            S_MARK:  if (fire) state_d = S_REGADDR;
            S_REGADDR: if (fire) begin
                if (idx_q == (mem_q ? 3'd7 : g_last)) begin state_d = S_SP2; idx_d = 3'd0; end
                else idx_d = idx_q + 3'd1;
            end
            S_SP2: if (fire) state_d = S_LT;
            S_LT:  if (fire) state_d = S_EQ;
            S_EQ:  if (fire) state_d = S_SP3;
            S_SP3: if (fire) state_d = S_DATA;
            S_DATA: if (fire) begin
                if (idx_q == 3'd7) begin state_d = S_HASH; idx_d = 3'd0; end
                else idx_d = idx_q + 3'd1;
            end
            S_HASH: if (fire) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Character for the upcoming state; '^' needs no latched data, so the start cycle is safe.
    always_comb begin
        char_d = 8'h00;
        case (state_d)
            S_CARET:   char_d = 8'h5e;
            S_TIME:    char_d = 8'h30 + 8'(tdig[2'(t_last - idx_d)]);
            S_AT:      char_d = 8'h40;
            S_PC:      char_d = hex_char(nib(pc_q, idx_d));
            S_COLON:   char_d = 8'h3a;
            S_SP1, S_SP2, S_SP3: char_d = 8'h20;
            S_MARK:    char_d = mem_q ? 8'h2a : 8'h24;
            S_REGADDR: char_d = mem_q ? hex_char(nib(addr_q, idx_d))
                                      : 8'h30 + 8'(gdig[1'(g_last - idx_d)]);
            S_LT:      char_d = 8'h3c;
            S_EQ:      char_d = 8'h3d;
            S_DATA:    char_d = hex_char(nib(data_q, idx_d));
            S_HASH:    char_d = 8'h23;
            default:   char_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            mem_q   <= 1'b0;
            time_q  <= '0;
            pc_q    <= '0;
            grf_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mem_q   <= mem_d;
            time_q  <= time_d;
            pc_q    <= pc_d;
            grf_q   <= grf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_char  = char_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
